// File: rtl/iserdes_align_pkg.sv
// Shared types and constants for the I_SERDES word aligner.
package iserdes_align_pkg;

  localparam int          ALIGN_DEFAULT_WIDTH   = 4;
  localparam logic [3:0]  ALIGN_DEFAULT_PATTERN = 4'b1100;
  localparam int          ALIGN_ERR_CNT_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_ERROR  = 3'd5
  } align_state_t;

endpackage

// File: rtl/iserdes_word_aligner.sv
// Word aligner behind a 1:4 I_SERDES: bitslips until the training word is seen MATCH_COUNT times.
// Optional lock monitor (ERR_CNT, loss-of-lock detection) enabled by ISERDES_ALIGN_MONITOR_EN.
module iserdes_word_aligner
  import iserdes_align_pkg::*;
#(
  parameter int               WIDTH         = ALIGN_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = ALIGN_DEFAULT_PATTERN,
  parameter int               MATCH_COUNT   = 8,
  parameter int               SETTLE_CYCLES = 4,
  parameter int               MAX_SLIPS     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PLL_LOCK,
  input  logic             TRAIN_EN,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             DATA_VALID,
  output logic             BITSLIP_ADJ,
  output logic             ALIGNED,
  output logic             ALIGN_ERR,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             DATA_OUT_VALID,
`ifdef ISERDES_ALIGN_MONITOR_EN
  output logic [ALIGN_ERR_CNT_W-1:0] ERR_CNT,
`endif
  output logic [2:0]       DBG_STATE
);

  localparam int MC_W = $clog2(MATCH_COUNT + 1);
  localparam int SL_W = $clog2(MAX_SLIPS + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [MC_W-1:0] MC_LAST   = MC_W'(MATCH_COUNT - 1);
  localparam logic [SL_W-1:0] SLIP_MAX  = SL_W'(MAX_SLIPS);
  localparam logic [ST_W-1:0] SETL_LAST = ST_W'(SETTLE_CYCLES - 1);

  align_state_t     r_state;
  logic [MC_W-1:0]  r_match_cnt;
  logic [SL_W-1:0]  r_slip_cnt;
  logic [ST_W-1:0]  r_settle_cnt;
  logic             r_bitslip;
  logic             r_aligned;
  logic             r_align_err;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_out_valid;
  logic             w_match;
`ifdef ISERDES_ALIGN_MONITOR_EN
  logic [ALIGN_ERR_CNT_W-1:0] r_err_cnt;
  logic [MC_W-1:0]            r_bad_cnt;
`endif

  // DATA_VALID qualifies DATA_IN on the same cycle; there is no backpressure, words are never stalled.
  assign w_match = (DATA_IN == TRAIN_PATTERN);

  always_ff @(posedge CLK) begin
    if (RST || !PLL_LOCK) begin
      r_state          <= ST_IDLE;
      r_match_cnt      <= '0;
      r_slip_cnt       <= '0;
      r_settle_cnt     <= '0;
      r_bitslip        <= 1'b0;
      r_aligned        <= 1'b0;
      r_align_err      <= 1'b0;
      r_data_out_valid <= 1'b0;
      if (RST) r_data_out <= '0;
`ifdef ISERDES_ALIGN_MONITOR_EN
      r_err_cnt        <= '0;
      r_bad_cnt        <= '0;
`endif
    end else begin
      r_bitslip        <= 1'b0;
      r_data_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_match_cnt  <= '0;
          r_slip_cnt   <= '0;
          r_settle_cnt <= '0;
          r_aligned    <= 1'b0;
`ifdef ISERDES_ALIGN_MONITOR_EN
          r_err_cnt    <= '0;
          r_bad_cnt    <= '0;
`endif
          if (TRAIN_EN) r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!TRAIN_EN) begin
            r_state <= ST_IDLE;
          end else if (DATA_VALID) begin
            if (w_match) begin
              r_match_cnt <= r_match_cnt + 1'b1;
              if (r_match_cnt == MC_LAST) begin
                r_state   <= ST_LOCKED;
                r_aligned <= 1'b1;
              end
            end else begin
              r_match_cnt <= '0;
              if (r_slip_cnt == SLIP_MAX) begin
                r_state     <= ST_ERROR;
                r_align_err <= 1'b1;
              end else begin
                r_state   <= ST_SLIP;
                r_bitslip <= 1'b1;
              end
            end
          end
        end
        ST_SLIP: begin
          r_slip_cnt   <= r_slip_cnt + 1'b1;
          r_settle_cnt <= '0;
          r_state      <= TRAIN_EN ? ST_SETTLE : ST_IDLE;
        end
        ST_SETTLE: begin
          // Words here may straddle the old and new boundary, so they are dropped unseen.
          if (!TRAIN_EN) begin
            r_state <= ST_IDLE;
          end else if (r_settle_cnt == SETL_LAST) begin
            r_settle_cnt <= '0;
            r_state      <= ST_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (DATA_VALID) begin
            r_data_out       <= DATA_IN;
            r_data_out_valid <= 1'b1;
          end
`ifdef ISERDES_ALIGN_MONITOR_EN
          if (TRAIN_EN && DATA_VALID && !w_match) begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            if (r_bad_cnt == MC_LAST) begin
              r_state          <= ST_CHECK;
              r_aligned        <= 1'b0;
              r_data_out_valid <= 1'b0;
              r_slip_cnt       <= '0;
              r_match_cnt      <= '0;
              r_bad_cnt        <= '0;
            end else begin
              r_bad_cnt <= r_bad_cnt + 1'b1;
            end
          end else if (DATA_VALID || !TRAIN_EN) begin
            r_bad_cnt <= '0;
          end
`endif
        end
        ST_ERROR: begin
          if (!TRAIN_EN) begin
            r_state     <= ST_IDLE;
            r_align_err <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign BITSLIP_ADJ    = r_bitslip;
  assign ALIGNED        = r_aligned;
  assign ALIGN_ERR      = r_align_err;
  assign DATA_OUT       = r_data_out;
  assign DATA_OUT_VALID = r_data_out_valid;
  assign DBG_STATE      = r_state;
`ifdef ISERDES_ALIGN_MONITOR_EN
  assign ERR_CNT        = r_err_cnt;
`endif

endmodule
